// File: rtl/evm_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : evm_timer_pkg                                          |
// | Description : Shared types and default constants for the 1 Hz        |
// |               seconds-tick receiver and countdown timer.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package evm_timer_pkg;

  // Countdown controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2
  } state_e;

  localparam int CLK_HZ_DEF = 100_000_000;
  localparam int SEC_W_DEF  = 8;

endpackage : evm_timer_pkg
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : edge_sync                                              |
// | Description : Two-flop synchronizer followed by a rising-edge        |
// |               detector with a registered one-cycle strobe output.    |
// |               Usable for any slow asynchronous level (1 Hz clock,    |
// |               push buttons).                                         |
// | Ports       : clk     - sampling clock, rising edge                  |
// |               rst_n   - asynchronous active-low reset                |
// |               i_async - asynchronous input level                     |
// |               o_tick  - one-cycle strobe per rising edge of i_async  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_tick
);

  logic r_s1;
  logic r_s2;
  logic r_s2d;
  logic r_tick;

  // r_s1 may go metastable; only r_s2 and later stages are used as logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s2d  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s2d  <= r_s2;
      r_tick <= r_s2 & ~r_s2d;
    end
  end

  assign o_tick = r_tick;

endmodule : edge_sync
`default_nettype wire

// File: rtl/sec_tick_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sec_tick_receiver                                      |
// | Description : Brings the free-running 1 Hz square wave into the fast |
// |               clock domain, turns each rising edge into a tick       |
// |               strobe, runs a loadable seconds countdown and flags a  |
// |               stalled 1 Hz source.                                   |
// | Ports       : clk_100MHz - fast clock, rising edge                   |
// |               rst_n      - asynchronous active-low reset             |
// |               clk1       - 1 Hz square wave (asynchronous)           |
// |               load       - load countdown with load_sec              |
// |               load_sec   - seconds to load                           |
// |               start      - begin counting (from LOADED)              |
// |               abort      - cancel the countdown                      |
// |               tick       - one-cycle strobe per clk1 rising edge     |
// |               secs_left  - remaining seconds                         |
// |               busy       - countdown running                         |
// |               done       - one-cycle pulse on expiry                 |
// |               tick_lost  - sticky watchdog flag, cleared by load     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sec_tick_receiver
  import evm_timer_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int GAP_CYCLES = CLK_HZ + CLK_HZ / 4,
  parameter int SEC_W      = SEC_W_DEF
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             clk1,
  input  logic             load,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             start,
  input  logic             abort,
  output logic             tick,
  output logic [SEC_W-1:0] secs_left,
  output logic             busy,
  output logic             done,
  output logic             tick_lost
);

  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic             w_tick;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [SEC_W-1:0] r_secs;
  logic [SEC_W-1:0] w_secs_nxt;
  logic             r_busy;
  logic             r_done;
  logic             w_done_nxt;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gap_nxt;
  logic             r_lost;

  edge_sync u_edge_sync (
    .clk     (clk_100MHz),
    .rst_n   (rst_n),
    .i_async (clk1),
    .o_tick  (w_tick)
  );

  // Next-state / countdown logic. abort outranks load, which outranks start.
  always_comb begin
    w_state_nxt = r_state;
    w_secs_nxt  = r_secs;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!abort && load) begin
          w_secs_nxt = load_sec;
          if (load_sec != '0) w_state_nxt = LOADED;
        end
      end
      LOADED: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_secs_nxt  = '0;
        end else if (load) begin
          w_secs_nxt = load_sec;
          if (load_sec == '0) w_state_nxt = IDLE;
        end else if (start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_secs_nxt  = '0;
        end else if (w_tick) begin
          if (r_secs == SEC_W'(1)) begin
            w_secs_nxt  = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else if (r_secs != '0) begin
            // Guarded so the counter can never wrap below zero
            w_secs_nxt = r_secs - SEC_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_secs_nxt  = '0;
      end
    endcase
  end

  // Gap counter restarts on each tick and saturates at its terminal value
  always_comb begin
    w_gap_nxt = r_gap;
    if (w_tick)                 w_gap_nxt = '0;
    else if (r_gap != GAP_LAST) w_gap_nxt = r_gap + GAP_W'(1);
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_secs  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gap   <= '0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_secs  <= w_secs_nxt;
      // busy tracks the state register exactly, so derive it from the next state
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= w_done_nxt;
      r_gap   <= w_gap_nxt;
      // The flag is raised on the edge the counter reaches its terminal value
      if (load)                         r_lost <= 1'b0;
      else if (w_gap_nxt == GAP_LAST)   r_lost <= 1'b1;
    end
  end

  assign tick      = w_tick;
  assign secs_left = r_secs;
  assign busy      = r_busy;
  assign done      = r_done;
  assign tick_lost = r_lost;

endmodule : sec_tick_receiver
`default_nettype wire

// File: tb/tb_sec_tick_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sec_tick_receiver                                   |
// | Description : Self-checking bench for sec_tick_receiver with a       |
// |               behavioural reference model.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sec_tick_receiver;

  localparam int CLK_HZ = 40;
  localparam int GAP    = 50;
  localparam int SW     = 8;

  logic          clk_100MHz = 1'b0;
  logic          rst_n      = 1'b1;
  logic          clk1       = 1'b0;
  logic          load       = 1'b0;
  logic [SW-1:0] load_sec   = '0;
  logic          start      = 1'b0;
  logic          abort      = 1'b0;
  logic          tick;
  logic [SW-1:0] secs_left;
  logic          busy;
  logic          done;
  logic          tick_lost;

  int checks = 0;
  int errors = 0;

  sec_tick_receiver #(
    .CLK_HZ     (CLK_HZ),
    .GAP_CYCLES (GAP),
    .SEC_W      (SW)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .clk1       (clk1),
    .load       (load),
    .load_sec   (load_sec),
    .start      (start),
    .abort      (abort),
    .tick       (tick),
    .secs_left  (secs_left),
    .busy       (busy),
    .done       (done),
    .tick_lost  (tick_lost)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // 1 Hz source: 40-cycle period, 20 high / 20 low; hold_low freezes it low
  int ph       = 20;
  int hold_low = 0;
  initial forever begin
    @(negedge clk_100MHz);
    if (hold_low > 0) begin
      hold_low = hold_low - 1;
      clk1     = 1'b0;
    end else begin
      ph   = (ph + 1) % 40;
      clk1 = (ph < 20);
    end
  end

  // ---------------- reference model ----------------
  // samp[k] = clk1 as sampled k edges ago (index 0 = this edge)
  logic [3:0]    samp   = '0;
  logic          m_tick = 1'b0;
  logic [SW-1:0] m_secs = '0;
  int            m_mode = 0;   // 0 idle, 1 loaded, 2 running
  logic          m_done = 1'b0;
  logic          m_lost = 1'b0;
  int            m_gap  = 0;   // cycles since the last tick, unbounded
  logic          t_seen;

  initial forever begin
    @(posedge clk_100MHz or negedge rst_n);
    if (!rst_n) begin
      samp = '0; m_tick = 1'b0; m_secs = '0; m_mode = 0;
      m_done = 1'b0; m_lost = 1'b0; m_gap = 0;
    end else begin
      t_seen = m_tick;
      m_done = 1'b0;
      if (abort) begin
        if (m_mode != 0) begin m_mode = 0; m_secs = '0; end
      end else if (m_mode == 2) begin
        if (t_seen && m_secs != 0) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin m_done = 1'b1; m_mode = 0; end
        end
      end else if (load) begin
        m_secs = load_sec;
        m_mode = (load_sec != 0) ? 1 : 0;
      end else if (start && m_mode == 1) begin
        m_mode = 2;
      end
      m_gap = t_seen ? 0 : m_gap + 1;
      if (load)                m_lost = 1'b0;
      else if (m_gap >= GAP-1) m_lost = 1'b1;
      // tick is high during the cycle after the edge where clk1 has been
      // seen high for exactly the third edge in a row after a low sample
      samp   = {samp[2:0], clk1};
      m_tick = samp[2] & ~samp[3];
    end
  end

  logic [SW+3:0] dut_vec;
  assign dut_vec = {tick, secs_left, busy, done, tick_lost};

  function automatic logic [SW+3:0] exp_vec();
    return {m_tick, m_secs, (m_mode == 2), m_done, m_lost};
  endfunction

  task automatic clr_inputs();
    load = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL reset_async dut=%h exp=0", dut_vec);
    end
    repeat (3) @(posedge clk_100MHz);
    @(negedge clk_100MHz) rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk_100MHz); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_hold t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_ticks();
    logic prev_tick = 1'b0;
    int   n_tick    = 0;
    repeat (130) begin
      @(posedge clk_100MHz); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ticks t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec());
      end
      if (tick && prev_tick) begin
        checks++; errors++; $display("FAIL tick_width t=%0t tick high two cycles, expected one", $time);
      end
      if (tick) n_tick++;
      prev_tick = tick;
    end
    checks++;
    if (n_tick < 3 || n_tick > 4) begin
      errors++; $display("FAIL tick_count got=%0d exp=3..4", n_tick);
    end
  endtask

  task automatic test_countdown();
    logic [SW-1:0] seq[$];
    int ndone = 0;
    int after = -1;
    load = 1'b1; load_sec = 8'd3;
    @(posedge clk_100MHz); #1;
    load = 1'b0; start = 1'b1;
    @(posedge clk_100MHz); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || secs_left !== 8'd3) begin
      errors++; $display("FAIL start_busy busy=%b secs=%0d exp busy=1 secs=3", busy, secs_left);
    end
    seq.push_back(secs_left);
    for (int i = 0; i < 200 && after != 0; i++) begin
      @(posedge clk_100MHz); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL countdown t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec());
      end
      if (secs_left != seq[$]) seq.push_back(secs_left);
      if (done) begin
        ndone++;
        checks++;
        if (secs_left !== 0 || busy !== 1'b0) begin
          errors++; $display("FAIL done_cycle secs=%0d busy=%b exp secs=0 busy=0", secs_left, busy);
        end
        if (after < 0) after = 3;
      end
      if (after > 0) after--;
    end
    checks++;
    if (ndone != 1) begin
      errors++; $display("FAIL done_pulses got=%0d exp=1", ndone);
    end
    checks++;
    if (seq.size() != 4 || seq[0] != 3 || seq[1] != 2 || seq[2] != 1 || seq[3] != 0) begin
      errors++; $display("FAIL secs_sequence got_len=%0d exp 3,2,1,0", seq.size());
    end
  endtask

  task automatic test_abort();
    int ndone = 0;
    bit hit   = 0;
    load = 1'b1; load_sec = 8'd3;
    @(posedge clk_100MHz); #1;
    load = 1'b0; start = 1'b1;
    @(posedge clk_100MHz); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk_100MHz); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL abort_run t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec());
      end
      if (m_mode == 2 && m_secs == 2) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_wait secs never reached 2, exp 2"); end
    abort = 1'b1;
    @(posedge clk_100MHz); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || secs_left !== 0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_run_exit busy=%b secs=%0d done=%b exp 0 0 0", busy, secs_left, done);
    end
    repeat (60) begin
      @(posedge clk_100MHz); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
    load = 1'b1; load_sec = 8'd4;
    @(posedge clk_100MHz); #1;
    load_sec = 8'd7; start = 1'b1; abort = 1'b1;
    @(posedge clk_100MHz); #1;
    clr_inputs();
    checks++;
    if (busy !== 1'b0 || secs_left !== 0) begin
      errors++; $display("FAIL abort_all_three busy=%b secs=%0d exp 0 0", busy, secs_left);
    end
  endtask

  task automatic test_load_zero();
    load = 1'b1; load_sec = 8'd0;
    @(posedge clk_100MHz); #1;
    load = 1'b0; start = 1'b1;
    @(posedge clk_100MHz); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || secs_left !== 0) begin
      errors++; $display("FAIL load_zero busy=%b secs=%0d exp 0 0", busy, secs_left);
    end
    load = 1'b1; load_sec = 8'd5; start = 1'b1;
    @(posedge clk_100MHz); #1;
    clr_inputs();
    checks++;
    if (busy !== 1'b0 || secs_left !== 8'd5) begin
      errors++; $display("FAIL load_start_same busy=%b secs=%0d exp 0 5", busy, secs_left);
    end
    repeat (3) begin
      @(posedge clk_100MHz); #1;
      checks++;
      if (dut_vec !== exp_vec() || busy !== 1'b0) begin
        errors++; $display("FAIL loaded_hold t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec());
      end
    end
    abort = 1'b1;
    @(posedge clk_100MHz); #1;
    abort = 1'b0;
  endtask

  task automatic test_watchdog();
    int  ndone    = 0;
    bit  lost_run = 0;
    hold_low = 60;
    repeat (140) begin
      @(posedge clk_100MHz); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL watchdog t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec());
      end
    end
    checks++;
    if (tick_lost !== 1'b1) begin errors++; $display("FAIL lost_sticky got=%b exp=1", tick_lost); end
    load = 1'b1; load_sec = 8'd6;
    @(posedge clk_100MHz); #1;
    load = 1'b0;
    checks++;
    if (tick_lost !== 1'b0) begin errors++; $display("FAIL lost_clear got=%b exp=0", tick_lost); end
    start = 1'b1;
    @(posedge clk_100MHz); #1;
    start = 1'b0;
    hold_low = 60;
    for (int i = 0; i < 500 && ndone == 0; i++) begin
      @(posedge clk_100MHz); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL watchdog_run t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec());
      end
      if (busy && tick_lost) lost_run = 1;
      if (done) ndone++;
    end
    checks++;
    if (!lost_run || ndone != 1) begin
      errors++; $display("FAIL count_while_lost lost_seen=%0d done=%0d exp 1 1", lost_run, ndone);
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      @(posedge clk_100MHz); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec());
      end
      load     = ($urandom_range(0, 11) == 0);
      load_sec = SW'($urandom_range(0, 4));
      start    = ($urandom_range(0, 5) == 0);
      abort    = ($urandom_range(0, 59) == 0);
      if (hold_low == 0 && $urandom_range(0, 299) == 0) hold_low = $urandom_range(30, 70);
    end
    clr_inputs();
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    abort = 1'b1;
    @(posedge clk_100MHz); #1;
    abort = 1'b0; load = 1'b1; load_sec = 8'd4;
    @(posedge clk_100MHz); #1;
    load = 1'b0; start = 1'b1;
    @(posedge clk_100MHz); #1;
    start = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(posedge clk_100MHz); #1;
      if (m_mode == 2 && m_secs == 2) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_wait secs never reached 2, exp 2"); end
    @(posedge clk_100MHz); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL rst_mid_run dut=%h exp=0", dut_vec); end
    repeat (3) begin
      @(posedge clk_100MHz); #1;
      checks++;
      if (dut_vec !== '0) begin errors++; $display("FAIL rst_held dut=%h exp=0", dut_vec); end
    end
    @(negedge clk_100MHz) rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk_100MHz); #1;
      checks++;
      if (dut_vec !== exp_vec() || done !== 1'b0) begin
        errors++; $display("FAIL rst_after t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ticks();
    test_countdown();
    test_abort();
    test_load_zero();
    test_watchdog();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sec_tick_receiver
`default_nettype wire

// File: doc/sec_tick_receiver.md
# sec_tick_receiver

Consumer end of the 1 Hz slow-clock path: takes the free-running 1 Hz square wave `clk1` back into the `clk_100MHz` domain. Synchronizes it, converts each rising edge into a single-cycle `tick` strobe, and runs a loadable seconds countdown for the voting session timeout. A watchdog flags a stalled or missing `clk1`. Sits between the 1 Hz divider and the EVM control FSM, which uses `busy`/`done` to open and close a voting window.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, fast-clock frequency; sizes the watchdog.
- `GAP_CYCLES`, CLK_HZ + CLK_HZ/4, maximum cycles allowed between ticks before `tick_lost`.
- `SEC_W`, 8, countdown width in seconds.

Ports:
- `clk_100MHz` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `clk1` in 1: 1 Hz square wave, asynchronous to this block.
- `load` in 1: load countdown value.
- `load_sec` in SEC_W: seconds to load.
- `start` in 1: begin countdown.
- `abort` in 1: cancel countdown.
- `tick` out 1: one-cycle strobe per `clk1` rising edge.
- `secs_left` out SEC_W: remaining seconds.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on expiry.
- `tick_lost` out 1: sticky watchdog flag.

## Operation
- Reset values: `tick`=0, `secs_left`=0, `busy`=0, `done`=0, `tick_lost`=0, state IDLE, sync flops 0, gap counter 0.
- Reset mid-countdown returns everything to reset values immediately; no `done` pulse.
- Edge path: two-flop synchronizer `s1`→`s2`, then `s2d` (`s2` delayed). Registered `tick <= s2 & ~s2d`. Falling edges produce nothing.
- FSM states:
  - IDLE: `load` with `load_sec`≠0 sets `secs_left`=`load_sec` and goes to LOADED. `load` with `load_sec`=0 sets `secs_left`=0 and stays in IDLE. `start` is ignored.
  - LOADED: `load` reloads `secs_left`; `load_sec`=0 returns to IDLE. Otherwise `start` goes to RUN.
  - RUN: each `tick` decrements `secs_left`. A `tick` while `secs_left`=1 sets `secs_left`=0, pulses `done` for one cycle and returns to IDLE. `load` and `start` are ignored.
- Priority in any state: `abort` > `load` > `start`.
  - `abort` in LOADED or RUN goes to IDLE with `secs_left`=0 and no `done`.
  - `abort` in IDLE has no effect.
- A tick in the same cycle as `start` is not counted; the state is still LOADED in that cycle.
- `busy` is registered and equals (state==RUN).
- No wrap-around: `secs_left` never decrements below 0.
- Watchdog: the gap counter clears on every `tick` and otherwise increments, saturating.
  - When it reaches GAP_CYCLES−1 it sets `tick_lost`.
  - `tick_lost` is cleared only by `rst_n` or `load`.
  - `tick_lost` does not stop the countdown.

## Timing
- `tick` latency: `clk1` is first sampled high at edge N (`s1`). `s2`=1 at N+1. `tick`=1 after N+2 and returns to 0 after N+3. Exactly one high cycle per rising edge.
- Countdown: `secs_left` updates on the cycle after the `tick` cycle. `done` and the return to IDLE (`busy`=0) occur at the same edge as the final decrement.
- `load`, `start` and `abort` take effect at the next edge. Outputs reflect them one cycle later.
- Gap counter width is $clog2(GAP_CYCLES+1), i.e. 27 bits at defaults.

## Structure
- Package `evm_timer_pkg` holds:
  - the state enum {IDLE, LOADED, RUN};
  - default constants CLK_HZ_DEF=100_000_000 and SEC_W_DEF=8.
- Sub-module `edge_sync`: synchronizer, `s2d` and registered `tick` output. It is reusable for the button inputs.
- Top level holds the FSM, countdown register and watchdog.

## Test plan
Simulation uses CLK_HZ=40, GAP_CYCLES=50, and `clk1` period 40 cycles (high 20 / low 20).
- Reset, then `clk1` toggling → first `tick` 3 edges after `clk1` is sampled high; exactly one tick per period; no tick on falling edges.
- `load` with `load_sec`=3, then `start` → `busy`=1; `secs_left` goes 3→2→1→0 on successive ticks; `done` high for exactly 1 cycle with the 0; `busy`=0 in that same cycle.
- `abort` asserted while `secs_left`=2 in RUN → IDLE, `secs_left`=0, `done` never pulses. `load`+`start`+`abort` asserted together in LOADED → IDLE.
- `load` with `load_sec`=0 → stays IDLE. `start` then has no effect. `load` with `load_sec`=5 and `start` in the same cycle → LOADED, `secs_left`=5, not RUN.
- Hold `clk1` low for 60 cycles → `tick_lost` set at gap 49 and stays set after ticks resume. `load` clears it. The countdown continues while `tick_lost`=1.
- Assert `rst_n`=0 mid-RUN, asynchronously between clock edges → all outputs 0 immediately; no `done` pulse.
